multicycle_int_core: RTL and testbench

- Parametrised integer execution core. Accepts one 32-bit RV integer instruction at a time over a valid/ready handshake.
- Each instruction passes through a 3-state FSM: FETCH, EXEC, WB.
- Owns the architectural register file and reports every instruction on a retire port.
- Successor to the single-cycle R/I datapath, adding:
  - sign-extended immediates
  - shifts, SLT/SLTU, LUI
  - x0 hardwired to zero
  - illegal-instruction detection
  - XLEN and register-count parameters.

---
 rtl/int_core_pkg.sv | 40 ++++
 rtl/int_alu.sv | 41 ++++
 rtl/multicycle_int_core.sv | 171 +++++++++++++++++
 tb/tb_multicycle_int_core.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_core_pkg.sv
// Shared encodings and enums for the multicycle integer core and its ALU.
package int_core_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluSll,
    AluSlt,
    AluSltu,
    AluXor,
    AluSrl,
    AluSra,
    AluOr,
    AluAnd,
    AluPassB
  } alu_op_e;

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StWb
  } state_e;

endpackage

// File: rtl/int_alu.sv
// Purely combinational integer ALU; shift amount comes from the low SHW bits of b.
module int_alu
  import int_core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result = '0;
    unique case (op)
      AluAdd:   result = a + b;
      AluSub:   result = a - b;
      AluSll:   result = a << shamt;
      AluSlt:   result = {{(XLEN-1){1'b0}}, lt_s};
      AluSltu:  result = {{(XLEN-1){1'b0}}, lt_u};
      AluXor:   result = a ^ b;
      AluSrl:   result = a >> shamt;
      AluSra:   result = $unsigned($signed(a) >>> shamt);
      AluOr:    result = a | b;
      AluAnd:   result = a & b;
      AluPassB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_int_core.sv
// Three-state (fetch/exec/writeback) RV integer core with its own register file
// and a retire port reporting every accepted instruction.
module multicycle_int_core
  import int_core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned RW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            retire_valid,
  output logic            retire_illegal,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  input  logic [RW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  state_e          state_q, state_d;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] res_q;
  logic            ill_q;
  logic [XLEN-1:0] rf_q [NREGS];

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_u, alu_b, alu_res;
  logic [31:0]     lui_word;
  alu_op_e         alu_op;
  logic            ill, use_rs1, use_rs2, use_rd, bad_shamt_hi;

  function automatic logic idx_ok(input logic [4:0] idx);
    return {1'b0, idx} < 6'(NREGS);
  endfunction

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7   = ir_q[31:25];
  assign lui_word = {ir_q[31:12], 12'b0};
  assign imm_i    = XLEN'($signed(ir_q[31:20]));
  assign imm_u    = XLEN'($signed(lui_word));

  // Out-of-range indices alias onto low registers; the instruction is illegal anyway.
  assign rs1_val  = (rs1 == 5'd0) ? '0 : rf_q[rs1[RW-1:0]];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : rf_q[rs2[RW-1:0]];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

  // On RV32 instr[25] would be shamt[5], which does not exist.
  assign bad_shamt_hi = ir_q[25] && (XLEN == 32);

  always_comb begin
    alu_op  = AluAdd;
    alu_b   = rs2_val;
    ill     = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (funct7 == F7_ALT) begin
          ill = !((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA));
        end else if (funct7 != F7_BASE) begin
          ill = 1'b1;
        end
        case (funct3)
          F3_ADD_SUB: alu_op = funct7[5] ? AluSub : AluAdd;
          F3_SLL:     alu_op = AluSll;
          F3_SLT:     alu_op = AluSlt;
          F3_SLTU:    alu_op = AluSltu;
          F3_XOR:     alu_op = AluXor;
          F3_SRL_SRA: alu_op = funct7[5] ? AluSra : AluSrl;
          F3_OR:      alu_op = AluOr;
          default:    alu_op = AluAnd;
        endcase
      end
      OPC_OPIMM: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        alu_b   = imm_i;
        case (funct3)
          F3_ADD_SUB: alu_op = AluAdd;
          F3_SLT:     alu_op = AluSlt;
          F3_SLTU:    alu_op = AluSltu;
          F3_XOR:     alu_op = AluXor;
          F3_OR:      alu_op = AluOr;
          F3_AND:     alu_op = AluAnd;
          F3_SLL: begin
            alu_op = AluSll;
            ill    = (ir_q[31:26] != 6'b0) || bad_shamt_hi;
          end
          default: begin
            alu_op = ir_q[30] ? AluSra : AluSrl;
            ill    = ({ir_q[31], ir_q[29:26]} != 5'b0) || bad_shamt_hi;
          end
        endcase
      end
      OPC_LUI: begin
        use_rd = 1'b1;
        alu_op = AluPassB;
        alu_b  = imm_u;
      end
      default: ill = 1'b1;
    endcase
    if ((use_rd && !idx_ok(rd)) || (use_rs1 && !idx_ok(rs1)) || (use_rs2 && !idx_ok(rs2))) begin
      ill = 1'b1;
    end
  end

  int_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .op    (alu_op),
    .a     (rs1_val),
    .b     (alu_b),
    .result(alu_res)
  );

  always_comb begin
    state_d      = state_q;
    instr_ready  = 1'b0;
    retire_valid = 1'b0;
    unique case (state_q)
      StFetch: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = StExec;
      end
      StExec: state_d = StWb;
      StWb: begin
        retire_valid = 1'b1;
        state_d      = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  assign retire_illegal = retire_valid && ill_q;
  assign retire_rd      = retire_valid ? rd : 5'd0;
  assign retire_data    = retire_valid ? res_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      ir_q    <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (instr_valid && instr_ready) ir_q <= instr;
      if (state_q == StExec) begin
        // RES already carries the architecturally reported value (0 for illegal or x0).
        res_q <= (ill || (rd == 5'd0)) ? '0 : alu_res;
        ill_q <= ill;
      end
      if ((state_q == StWb) && !ill_q && (rd != 5'd0)) rf_q[rd[RW-1:0]] <= res_q;
    end
  end

endmodule

// File: tb/tb_multicycle_int_core.sv
// Bench for multicycle_int_core: table-driven RV32 vectors with a retire scoreboard,
// reset/idle corner sequences, and a second XLEN=64 / NREGS=16 instance.
module tb_multicycle_int_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        retire_valid, retire_illegal;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  logic        instr_valid2 = 1'b0;
  logic        instr_ready2;
  logic [31:0] instr2 = '0;
  logic        retire_valid2, retire_illegal2;
  logic [4:0]  retire_rd2;
  logic [63:0] retire_data2;
  logic [3:0]  dbg_addr2 = '0;
  logic [63:0] dbg_data2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } ret_t;

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } vec_t;

  ret_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_int_core dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .retire_valid  (retire_valid),
    .retire_illegal(retire_illegal),
    .retire_rd     (retire_rd),
    .retire_data   (retire_data),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  multicycle_int_core #(
    .XLEN (64),
    .NREGS(16)
  ) dut64 (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid2),
    .instr_ready   (instr_ready2),
    .instr         (instr2),
    .retire_valid  (retire_valid2),
    .retire_illegal(retire_illegal2),
    .retire_rd     (retire_rd2),
    .retire_data   (retire_data2),
    .dbg_addr      (dbg_addr2),
    .dbg_data      (dbg_data2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  // Scoreboard: every retire pulse of the 32-bit core must match the oldest pending entry.
  always @(negedge clk) begin
    if (retire_valid) begin
      if (sb.size() == 0) begin
        check("spurious_retire", 64'(retire_valid), 64'd0);
      end else begin
        ret_t e;
        e = sb.pop_front();
        check("sb_rd", 64'(retire_rd), 64'(e.rd));
        check("sb_data", 64'(retire_data), 64'(e.data));
        check("sb_illegal", 64'(retire_illegal), 64'(e.ill));
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [4:0] rd, input logic [31:0] data,
                       input logic ill, input string name);
    int n = 0;
    while (!instr_ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!instr_ready) check({name, "_ready_timeout"}, 64'(instr_ready), 64'd1);
    instr       = ins;
    instr_valid = 1'b1;
    sb.push_back('{rd: rd, data: data, ill: ill});
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = ~ins;  // must be ignored once latched
    @(negedge clk);
    check({name, "_exec_no_retire"}, 64'(retire_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({name, "_wb_retire"}, 64'(retire_valid), 64'd1);
    check({name, "_wb_not_ready"}, 64'(instr_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue64(input logic [31:0] ins, input logic [4:0] rd, input logic [63:0] data,
                         input logic ill, input string name);
    int n = 0;
    while (!instr_ready2 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!instr_ready2) check({name, "_ready_timeout"}, 64'(instr_ready2), 64'd1);
    instr2       = ins;
    instr_valid2 = 1'b1;
    @(posedge clk);
    #1;
    instr_valid2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, 64'(retire_valid2), 64'd1);
    check({name, "_rd"}, 64'(retire_rd2), 64'(rd));
    check({name, "_data"}, retire_data2, data);
    check({name, "_illegal"}, 64'(retire_illegal2), 64'(ill));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back('{32'hFFF00093, 5'd1, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{enc_i(12'd5, 5'd0, 3'b000, 5'd1), 5'd1, 32'd5, 1'b0});
    vecs.push_back('{enc_i(12'd7, 5'd0, 3'b000, 5'd2), 5'd2, 32'd7, 1'b0});
    vecs.push_back('{enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 5'd3, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd4), 5'd4, 32'd1, 1'b0});
    vecs.push_back('{enc_r(7'h00, 5'd1, 5'd3, 3'b010, 5'd5), 5'd5, 32'd1, 1'b0});
    vecs.push_back('{enc_u(20'h80000, 5'd1), 5'd1, 32'h80000000, 1'b0});
    vecs.push_back('{enc_i({7'h20, 5'd4}, 5'd1, 3'b101, 5'd6), 5'd6, 32'hF8000000, 1'b0});
    vecs.push_back('{enc_i(12'd4, 5'd1, 3'b101, 5'd7), 5'd7, 32'h08000000, 1'b0});
    vecs.push_back('{enc_i(12'd5, 5'd0, 3'b000, 5'd0), 5'd0, 32'd0, 1'b0});
    vecs.push_back('{32'h0000007F, 5'd0, 32'd0, 1'b1});
    vecs.push_back('{enc_i(12'd1, 5'd6, 3'b001, 5'd8), 5'd8, 32'hF0000000, 1'b0});
    vecs.push_back('{enc_i(12'hFFF, 5'd2, 3'b011, 5'd9), 5'd9, 32'd1, 1'b0});
    vecs.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd10), 5'd10, 32'h80000007, 1'b0});
    vecs.push_back('{enc_r(7'h00, 5'd2, 5'd6, 3'b110, 5'd11), 5'd11, 32'hF8000007, 1'b0});
    vecs.push_back('{enc_r(7'h00, 5'd2, 5'd3, 3'b111, 5'd12), 5'd12, 32'd6, 1'b0});
    vecs.push_back('{enc_i({7'h01, 5'd1}, 5'd1, 3'b001, 5'd13), 5'd13, 32'd0, 1'b1});
    vecs.push_back('{enc_r(7'h20, 5'd2, 5'd1, 3'b100, 5'd14), 5'd14, 32'd0, 1'b1});
    vecs.push_back('{enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd15), 5'd15, 32'hFF000000, 1'b0});
    vecs.push_back('{enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd16), 5'd16, 32'd0, 1'b0});
    vecs.push_back('{enc_i(12'hFFF, 5'd3, 3'b010, 5'd17), 5'd17, 32'd1, 1'b0});
    vecs.push_back('{enc_i(12'h0FF, 5'd2, 3'b100, 5'd18), 5'd18, 32'h000000F8, 1'b0});
    vecs.push_back('{enc_i(12'h0F0, 5'd3, 3'b111, 5'd19), 5'd19, 32'h000000F0, 1'b0});
    vecs.push_back('{enc_i(12'hFF0, 5'd0, 3'b110, 5'd20), 5'd20, 32'hFFFFFFF0, 1'b0});
    vecs.push_back('{enc_r(7'h00, 5'd2, 5'd6, 3'b101, 5'd21), 5'd21, 32'h01F00000, 1'b0});
    vecs.push_back('{enc_r(7'h00, 5'd2, 5'd2, 3'b001, 5'd22), 5'd22, 32'h00000380, 1'b0});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(instr_ready), 64'd1);
    check("rst_retire_valid", 64'(retire_valid), 64'd0);
    check("rst_retire_illegal", 64'(retire_illegal), 64'd0);
    check("rst_retire_rd", 64'(retire_rd), 64'd0);
    check("rst_retire_data", 64'(retire_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // First vector then its debug read-back
    issue(vecs[0].ins, vecs[0].rd, vecs[0].data, vecs[0].ill, "vec0");
    dbg_addr = 5'd1;
    #1;
    check("dbg_x1_after_addi", 64'(dbg_data), 64'hFFFFFFFF);

    for (int i = 1; i < vecs.size(); i++) begin
      issue(vecs[i].ins, vecs[i].rd, vecs[i].data, vecs[i].ill, $sformatf("vec%0d", i));
    end

    dbg_addr = 5'd0;
    #1;
    check("dbg_x0", 64'(dbg_data), 64'd0);
    dbg_addr = 5'd13;
    #1;
    check("dbg_x13_illegal_nowrite", 64'(dbg_data), 64'd0);
    dbg_addr = 5'd22;
    #1;
    check("dbg_x22", 64'(dbg_data), 64'h380);

    // Idle: no retire, always ready
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", 64'(instr_ready), 64'd1);
      check("idle_no_retire", 64'(retire_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Reset during EXEC discards the instruction
    instr       = enc_i(12'd3, 5'd0, 3'b000, 5'd8);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_no_retire", 64'(retire_valid), 64'd0);
    check("midrst_ready", 64'(instr_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    dbg_addr = 5'd8;
    #1;
    check("midrst_x8_zero", 64'(dbg_data), 64'd0);
    dbg_addr = 5'd1;
    #1;
    check("midrst_x1_cleared", 64'(dbg_data), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_ready", 64'(instr_ready), 64'd1);
      check("post_rst_no_retire", 64'(retire_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    issue(enc_i(12'd3, 5'd0, 3'b000, 5'd8), 5'd8, 32'd3, 1'b0, "post_rst_addi");
    dbg_addr = 5'd8;
    #1;
    check("post_rst_x8", 64'(dbg_data), 64'd3);

    // XLEN=64, NREGS=16 instance
    issue64(enc_i(12'd1, 5'd0, 3'b000, 5'd1), 5'd1, 64'd1, 1'b0, "w64_addi");
    issue64(enc_i(12'd40, 5'd1, 3'b001, 5'd2), 5'd2, 64'h0000_0100_0000_0000, 1'b0, "w64_slli40");
    issue64(enc_u(20'h80000, 5'd3), 5'd3, 64'hFFFF_FFFF_8000_0000, 1'b0, "w64_lui");
    issue64(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd17), 5'd17, 64'd0, 1'b1, "w64_add_x17");
    issue64(enc_i(12'hFFF, 5'd0, 3'b000, 5'd15), 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "w64_x15");
    dbg_addr2 = 4'd2;
    #1;
    check("w64_dbg_x2", dbg_data2, 64'h0000_0100_0000_0000);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
